ssd_bcd_tdm_ctrl: RTL

//  Sequencer and scan controller for the 4-digit seven-segment display path of the counter_ssd_tdm project.
//  - Accepts a 10-bit binary value over a valid/ready handshake.
//  - Converts it to four BCD digits with a sequential shift-add-3 engine, one bit per cycle.
//  - Swaps the result into the display buffer only at a frame boundary, so the display never tears.
//  - Time-multiplexes the four digits onto shared anode/segment pins, with leading-zero blanking.

---
 rtl/ssd_pkg.sv | 59 +++++
 rtl/bcd_dabble_seq.sv | 91 +++++++++
 rtl/ssd_bcd_tdm_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_pkg
//  Description : Shared glyph constants, digit typedefs and BCD helpers for
//                the seven-segment display path.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bcd_digit_t;

    localparam int BIN_W = 10;
    localparam int BCD_W = 16;

    // Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied at the pins.
    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    function automatic logic [6:0] seg_decode(input bcd_digit_t d);
        logic [6:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_OFF;
        endcase
        return g;
    endfunction

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] r;
        r = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_dabble_seq
//  Description : Sequential shift-add-3 binary to BCD converter, one bit per
//                cycle, behind a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_dabble_seq
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic [BCD_W-1:0] res_o,
    output logic             res_valid_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
    localparam logic [3:0] c_LAST_SHIFT = 4'd9;

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] bin_q,   bin_d;
    logic [BCD_W-1:0] bcd_q,   bcd_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic             ready_q, ready_d;
    logic [BCD_W-1:0] w_adj;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        w_adj   = dabble_adjust(bcd_q);
        case (state_q)
            c_IDLE: begin
                ready_d = 1'b1;
                if (valid_i && ready_q) begin
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = c_SHIFT;
                    ready_d = 1'b0;
                end
            end
            c_SHIFT: begin
                {bcd_d, bin_d} = {w_adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == c_LAST_SHIFT) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Ready is registered so it stays low through the reset cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o     = ready_q;
    assign busy_o      = (state_q != c_IDLE);
    assign res_o       = bcd_q;
    assign res_valid_o = (state_q == c_DONE);

endmodule
`default_nettype wire

// File: rtl/ssd_bcd_tdm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_bcd_tdm_ctrl
//  Description : Binary-to-BCD sequencer with tear-free frame swap and a
//                4-digit time-multiplexed seven-segment scan.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssd_bcd_tdm_ctrl
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    output logic             bin_ready,
    output logic             conv_busy,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);

    localparam int                 c_CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(REFRESH_DIV - 1);
    localparam digit_idx_t         c_LAST_IDX = 2'd3;

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t         idx_q, idx_d;
    logic [BCD_W-1:0]   pend_q, pend_d;
    logic               pend_flag_q, pend_flag_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic               w_tick;
    logic               w_swap;
    logic [3:0]         w_blank;
    bcd_digit_t         w_digit;
    logic [BCD_W-1:0]   w_res;
    logic               w_res_valid;

    bcd_dabble_seq u_dabble (
        .clk         (clk),
        .rst         (rst),
        .bin_i       (bin_in),
        .valid_i     (bin_valid),
        .ready_o     (bin_ready),
        .busy_o      (conv_busy),
        .res_o       (w_res),
        .res_valid_o (w_res_valid)
    );

    always_comb begin
        w_tick = (cnt_q == c_CNT_MAX);
        cnt_d  = w_tick ? '0 : cnt_q + 1'b1;
        idx_d  = w_tick ? idx_q + 2'd1 : idx_q;

        // Swap only as the scan wraps to digit 0 so a frame never mixes values.
        w_swap = w_tick && (idx_q == c_LAST_IDX) && pend_flag_q;
        disp_d = w_swap ? pend_q : disp_q;

        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        if (w_swap) begin
            pend_flag_d = 1'b0;
        end
        if (w_res_valid) begin
            pend_d      = w_res;
            pend_flag_d = 1'b1;
        end

        w_blank[3] = (disp_d[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (disp_d[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (disp_d[7:4] == 4'd0);
        w_blank[0] = 1'b0;

        w_digit = disp_d[{idx_d, 2'b00} +: 4];
        an_d    = 4'b0000;
        seg_d   = SEG_OFF;
        if (!w_blank[idx_d]) begin
            an_d[idx_d] = 1'b1;
            seg_d       = seg_decode(w_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            disp_q      <= '0;
            an_q        <= '0;
            seg_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            disp_q      <= disp_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an  = an_q  ^ {4{ACTIVE_LOW}};
    assign seg = seg_q ^ {7{ACTIVE_LOW}};
    assign dp  = ACTIVE_LOW;

endmodule
`default_nettype wire
